// File: rtl/dab_seq_pkg.sv
// Shared encodings, widths and legal command limits for the DAB modulator sequencer.
package dab_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } seq_state_t;

  localparam int T_W     = 9;
  localparam int RAZON_W = 12;

  localparam logic signed [T_W-1:0] T_MIN   = 9'sd0;
  localparam logic signed [T_W-1:0] T_MAX   = 9'sd255;
  localparam logic signed [T_W-1:0] PHI_MIN = -9'sd255;
  localparam logic signed [T_W-1:0] PHI_MAX = 9'sd255;
  localparam logic [RAZON_W-1:0]    RAZON_MIN = 12'd2;

  // Field range check only; the razon-vs-current-period rule depends on state and lives in the top.
  function automatic logic cmd_fields_legal(
    input logic signed [T_W-1:0] t1,
    input logic signed [T_W-1:0] t2,
    input logic signed [T_W-1:0] phi,
    input logic [RAZON_W-1:0]    razon
  );
    return (t1 >= T_MIN) && (t1 <= T_MAX) &&
           (t2 >= T_MIN) && (t2 <= T_MAX) &&
           (phi >= PHI_MIN) && (phi <= PHI_MAX) &&
           (razon >= RAZON_MIN);
  endfunction

endpackage

// File: rtl/slew_stepper.sv
// One channel of slew-limited stepping: moves cur toward goal by at most SLEW per step, never overshooting.
module slew_stepper #(
  parameter int WIDTH = 9,
  parameter int SLEW  = 8
) (
  input  logic signed [WIDTH-1:0] cur,
  input  logic signed [WIDTH-1:0] goal,
  input  logic                    step_en,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] load_val,
  output logic signed [WIDTH-1:0] nxt,
  output logic                    at_goal
);

  localparam logic signed [WIDTH:0]   SLEW_W = (WIDTH+1)'(SLEW);
  localparam logic signed [WIDTH-1:0] SLEW_N = WIDTH'(SLEW);

  // One extra bit so goal-cur spans the full -510..510 range without wrapping.
  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] mag;

  // Next value: load wins, otherwise snap to goal when within one slew step, else move one step.
  always_comb begin
    diff = {goal[WIDTH-1], goal} - {cur[WIDTH-1], cur};
    mag  = diff[WIDTH] ? -diff : diff;
    nxt  = cur;
    if (load) begin
      nxt = load_val;
    end else if (step_en) begin
      if (mag <= SLEW_W) begin
        nxt = goal;
      end else if (diff[WIDTH]) begin
        nxt = cur - SLEW_N;
      end else begin
        nxt = cur + SLEW_N;
      end
    end
  end

  assign at_goal = (cur == goal);

endmodule

// File: rtl/dab_mod_sequencer.sv
// DAB modulator sequencer: command intake/validation, start/stop sequencing and per-period slew limiting.
//
//   state | meaning
//   IDLE  | outputs held at zero, waiting for enable
//   ARM   | single cycle, sync pulse to modulator, optional direct load
//   RUN   | ramp toward stored targets on each period_tick
//   STOP  | ramp toward zero; back to IDLE once all channels are zero
module dab_mod_sequencer
  import dab_seq_pkg::*;
#(
  parameter int                 SLEW_T    = 8,
  parameter int                 SLEW_PHI  = 4,
  parameter logic [RAZON_W-1:0] RAZON_RST = 12'd1000,
  parameter bit                 SOFTSTART = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CE,
  input  logic                    enable,
  input  logic                    period_tick,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [T_W-1:0]   cmd_t1,
  input  logic signed [T_W-1:0]   cmd_t2,
  input  logic signed [T_W-1:0]   cmd_phi,
  input  logic [RAZON_W-1:0]      cmd_razon,
  output logic signed [T_W-1:0]   t1,
  output logic signed [T_W-1:0]   t2,
  output logic signed [T_W-1:0]   phi,
  output logic [RAZON_W-1:0]      razon_clk,
  output logic                    sync,
  output logic                    cmd_err,
  output logic                    busy,
  output logic [1:0]              state
);

  seq_state_t state_q, state_d;

  logic signed [T_W-1:0] t1_q, t2_q, phi_q;
  logic signed [T_W-1:0] tgt_t1_q, tgt_t2_q, tgt_phi_q;
  logic signed [T_W-1:0] tgt_t1_d, tgt_t2_d, tgt_phi_d;
  logic signed [T_W-1:0] t1_goal, t2_goal, phi_goal;
  logic signed [T_W-1:0] t1_ld, t2_ld, phi_ld;
  logic signed [T_W-1:0] t1_nxt, t2_nxt, phi_nxt;
  logic                  t1_at, t2_at, phi_at;
  logic                  ld_en, step_en;
  logic [RAZON_W-1:0]    razon_q;
  logic                  ready_en_q, sync_q, err_q, busy_q, busy_d;
  logic                  accept, cmd_ok, store, reject;

  assign cmd_ready = ready_en_q && (state_q != ST_ARM);
  assign accept    = cmd_valid && cmd_ready && CE;
  // While running, the period is locked: only a matching razon is accepted.
  assign cmd_ok    = cmd_fields_legal(cmd_t1, cmd_t2, cmd_phi, cmd_razon) &&
                     ((state_q == ST_IDLE) || (cmd_razon == razon_q));
  assign store     = accept && cmd_ok;
  assign reject    = accept && !cmd_ok;

  // Goal selection uses enable directly so an enable change coinciding with a tick already steps the new way.
  always_comb begin
    t1_goal  = '0;
    t2_goal  = '0;
    phi_goal = '0;
    if (((state_q == ST_RUN) || (state_q == ST_STOP)) && enable) begin
      t1_goal  = tgt_t1_q;
      t2_goal  = tgt_t2_q;
      phi_goal = tgt_phi_q;
    end
    ld_en   = (state_q == ST_IDLE) || (state_q == ST_ARM);
    t1_ld   = '0;
    t2_ld   = '0;
    phi_ld  = '0;
    if ((state_q == ST_ARM) && !SOFTSTART) begin
      t1_ld  = tgt_t1_q;
      t2_ld  = tgt_t2_q;
      phi_ld = tgt_phi_q;
    end
    step_en = CE && period_tick && ((state_q == ST_RUN) || (state_q == ST_STOP));
  end

  slew_stepper #(.WIDTH(T_W), .SLEW(SLEW_T)) u_step_t1 (
    .cur(t1_q), .goal(t1_goal), .step_en(step_en), .load(ld_en), .load_val(t1_ld),
    .nxt(t1_nxt), .at_goal(t1_at)
  );

  slew_stepper #(.WIDTH(T_W), .SLEW(SLEW_T)) u_step_t2 (
    .cur(t2_q), .goal(t2_goal), .step_en(step_en), .load(ld_en), .load_val(t2_ld),
    .nxt(t2_nxt), .at_goal(t2_at)
  );

  slew_stepper #(.WIDTH(T_W), .SLEW(SLEW_PHI)) u_step_phi (
    .cur(phi_q), .goal(phi_goal), .step_en(step_en), .load(ld_en), .load_val(phi_ld),
    .nxt(phi_nxt), .at_goal(phi_at)
  );

  // Next state, next targets and the post-update busy flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      ST_STOP: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (t1_at && t2_at && phi_at) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tgt_t1_d  = tgt_t1_q;
    tgt_t2_d  = tgt_t2_q;
    tgt_phi_d = tgt_phi_q;
    if (store) begin
      tgt_t1_d  = cmd_t1;
      tgt_t2_d  = cmd_t2;
      tgt_phi_d = cmd_phi;
    end

    busy_d = (state_d == ST_STOP) ||
             (((state_d == ST_RUN) || (state_d == ST_ARM)) &&
              ((t1_nxt != tgt_t1_d) || (t2_nxt != tgt_t2_d) || (phi_nxt != tgt_phi_d)));
  end

  // Main state, effective values, targets and period; everything holds while CE is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      t1_q      <= '0;
      t2_q      <= '0;
      phi_q     <= '0;
      tgt_t1_q  <= '0;
      tgt_t2_q  <= '0;
      tgt_phi_q <= '0;
      razon_q   <= RAZON_RST;
      busy_q    <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      t1_q      <= t1_nxt;
      t2_q      <= t2_nxt;
      phi_q     <= phi_nxt;
      tgt_t1_q  <= tgt_t1_d;
      tgt_t2_q  <= tgt_t2_d;
      tgt_phi_q <= tgt_phi_d;
      if (store && (state_q == ST_IDLE)) begin
        razon_q <= cmd_razon;
      end
      busy_q    <= busy_d;
    end
  end

  // Single-cycle pulses clear on any edge so a CE stall can never stretch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
      sync_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      sync_q     <= CE && (state_d == ST_ARM);
      err_q      <= reject;
    end
  end

  assign t1        = t1_q;
  assign t2        = t2_q;
  assign phi       = phi_q;
  assign razon_clk = razon_q;
  assign sync      = sync_q;
  assign cmd_err   = err_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_dab_mod_sequencer.sv
// Directed bench for dab_mod_sequencer: ramp tables, command validation table and hand-written sequences.
module tb_dab_mod_sequencer;

  logic              clk, rst, CE, enable, period_tick, cmd_valid;
  logic              cmd_ready, sync, cmd_err, busy;
  logic signed [8:0] cmd_t1, cmd_t2, cmd_phi, t1, t2, phi;
  logic [11:0]       cmd_razon, razon_clk;
  logic [1:0]        state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int t1; int phi; bit busy; } ramp_t;
  typedef struct { int c_t1; int c_t2; int c_phi; int c_razon; bit err; } cmdv_t;

  ramp_t ramp[13];
  cmdv_t cmds[5];

  dab_mod_sequencer dut (
    .clk(clk), .rst(rst), .CE(CE), .enable(enable), .period_tick(period_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_t1(cmd_t1), .cmd_t2(cmd_t2),
    .cmd_phi(cmd_phi), .cmd_razon(cmd_razon), .t1(t1), .t2(t2), .phi(phi),
    .razon_clk(razon_clk), .sync(sync), .cmd_err(cmd_err), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    period_tick = 1'b1;
    cyc();
    period_tick = 1'b0;
  endtask

  task automatic set_cmd(input int a, input int b, input int c, input int r);
    cmd_t1    = 9'(a);
    cmd_t2    = 9'(b);
    cmd_phi   = 9'(c);
    cmd_razon = 12'(r);
  endtask

  task automatic send_cmd(input int a, input int b, input int c, input int r);
    set_cmd(a, b, c, r);
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    ramp[0]  = '{8, 4, 1};   ramp[1]  = '{16, 8, 1};  ramp[2]  = '{24, 10, 1};
    ramp[3]  = '{32, 10, 1}; ramp[4]  = '{40, 10, 1}; ramp[5]  = '{48, 10, 1};
    ramp[6]  = '{56, 10, 1}; ramp[7]  = '{64, 10, 1}; ramp[8]  = '{72, 10, 1};
    ramp[9]  = '{80, 10, 1}; ramp[10] = '{88, 10, 1}; ramp[11] = '{96, 10, 1};
    ramp[12] = '{100, 10, 0};
    cmds[0] = '{300, 100, -20, 1000, 1'b1};
    cmds[1] = '{100, 100, -256, 1000, 1'b1};
    cmds[2] = '{100, 100, -20, 1500, 1'b1};
    cmds[3] = '{100, 100, -20, 1, 1'b1};
    cmds[4] = '{100, 100, -20, 1000, 1'b0};

    rst = 1'b1; CE = 1'b1; enable = 1'b0; period_tick = 1'b0; cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_t1", t1, 0);
    chk("rst_razon", razon_clk, 1000);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_sync", sync, 0);
    chk("rst_busy", busy, 0);
    cyc();
    chk("rst_ready_held", cmd_ready, 0);
    rst = 1'b1;
    cyc();
    chk("ready_after_rel", cmd_ready, 1);

    // 1: start and soft-start ramp
    send_cmd(100, 100, 10, 1000);
    chk("t1_cmd_err", cmd_err, 0);
    enable = 1'b1;
    cyc();
    chk("arm_state", state, 1);
    chk("arm_sync", sync, 1);
    chk("arm_ready", cmd_ready, 0);
    cyc();
    chk("run_state", state, 2);
    chk("sync_one_cycle", sync, 0);
    chk("run_t1_start", t1, 0);
    chk("run_busy", busy, 1);
    for (int i = 0; i < 13; i++) begin
      do_tick();
      chk("ramp_t1", $signed(t1), ramp[i].t1);
      chk("ramp_t2", $signed(t2), ramp[i].t1);
      chk("ramp_phi", $signed(phi), ramp[i].phi);
      chk("ramp_busy", busy, int'(ramp[i].busy));
      cyc();
      chk("ramp_hold", $signed(t1), ramp[i].t1);
    end

    // 2: phi retarget down past zero
    send_cmd(100, 100, -20, 1000);
    chk("phi_cmd_busy", busy, 1);
    for (int k = 1; k <= 8; k++) begin
      do_tick();
      chk("phi_down", $signed(phi), (10 - 4*k < -20) ? -20 : 10 - 4*k);
      chk("phi_down_t1", $signed(t1), 100);
    end
    chk("phi_done_busy", busy, 0);

    // 3: command validation table
    for (int i = 0; i < 5; i++) begin
      chk("val_ready", cmd_ready, 1);
      send_cmd(cmds[i].c_t1, cmds[i].c_t2, cmds[i].c_phi, cmds[i].c_razon);
      chk("val_err", cmd_err, int'(cmds[i].err));
      cyc();
      chk("val_err_pulse", cmd_err, 0);
    end
    do_tick();
    chk("val_t1_kept", $signed(t1), 100);
    chk("val_phi_kept", $signed(phi), -20);
    chk("val_razon_kept", razon_clk, 1000);

    // 4: stop with coincident tick, ramp to IDLE, restart, partial stop and reversal
    enable = 1'b0;
    do_tick();
    chk("stop_state", state, 3);
    chk("stop_first_t1", $signed(t1), 92);
    chk("stop_first_phi", $signed(phi), -16);
    for (int k = 1; k <= 12; k++) begin
      do_tick();
      chk("stop_t1", $signed(t1), (92 - 8*k < 0) ? 0 : 92 - 8*k);
      chk("stop_st", state, 3);
    end
    cyc();
    chk("stop_idle", state, 0);
    chk("stop_busy", busy, 0);
    chk("stop_t2", $signed(t2), 0);
    chk("stop_phi", $signed(phi), 0);
    send_cmd(100, 100, -20, 1500);
    chk("idle_razon", razon_clk, 1500);
    chk("idle_razon_err", cmd_err, 0);
    enable = 1'b1;
    cyc();
    chk("rearm_sync", sync, 1);
    cyc();
    chk("rerun_state", state, 2);
    for (int k = 1; k <= 13; k++) begin
      do_tick();
      chk("reup_t1", $signed(t1), (8*k > 100) ? 100 : 8*k);
    end
    enable = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      do_tick();
      chk("part_down_t1", $signed(t1), 100 - 8*k);
    end
    chk("part_down_st", state, 3);
    enable = 1'b1;
    cyc();
    chk("reverse_state", state, 2);
    chk("reverse_sync", sync, 0);
    for (int k = 1; k <= 6; k++) begin
      do_tick();
      chk("reverse_t1", $signed(t1), 52 + 8*k);
      chk("reverse_sync", sync, 0);
    end
    chk("reverse_phi", $signed(phi), -20);
    chk("reverse_t2", $signed(t2), 100);

    // 5: tick coincident with accept uses old goal, then CE stall
    set_cmd(60, 100, -20, 1500);
    cmd_valid = 1'b1;
    period_tick = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    period_tick = 1'b0;
    chk("coinc_t1_old_goal", $signed(t1), 100);
    CE = 1'b0;
    set_cmd(0, 100, -20, 1500);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      period_tick = (i == 3) || (i == 8) || (i == 13);
      cyc();
      chk("ce_t1", $signed(t1), 100);
      chk("ce_err", cmd_err, 0);
      chk("ce_sync", sync, 0);
    end
    CE = 1'b1;
    cmd_valid = 1'b0;
    period_tick = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      do_tick();
      chk("ce_resume_t1", $signed(t1), (100 - 8*k < 60) ? 60 : 100 - 8*k);
    end

    // 6: reset mid-ramp
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (state == 2'd0) break;
      do_tick();
    end
    chk("pre_rst_idle", state, 0);
    enable = 1'b1;
    cyc();
    cyc();
    for (int k = 1; k <= 5; k++) do_tick();
    chk("pre_rst_t1", $signed(t1), 40);
    #2 rst = 1'b0;
    #1;
    chk("async_t1", $signed(t1), 0);
    chk("async_t2", $signed(t2), 0);
    chk("async_phi", $signed(phi), 0);
    chk("async_state", state, 0);
    chk("async_ready", cmd_ready, 0);
    chk("async_busy", busy, 0);
    enable = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_razon", razon_clk, 1000);
    send_cmd(24, 16, -8, 1000);
    enable = 1'b1;
    cyc();
    chk("post_rst_sync", sync, 1);
    cyc();
    chk("post_rst_run", state, 2);
    chk("post_rst_t1_0", $signed(t1), 0);
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      chk("post_rst_t1", $signed(t1), 8*k);
      chk("post_rst_t2", $signed(t2), (8*k > 16) ? 16 : 8*k);
      chk("post_rst_phi", $signed(phi), (-4*k < -8) ? -8 : -4*k);
    end
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
